// File: rtl/regbank_pkg.sv
// Shared types and helpers for the 16 x 32-bit register bank write-back path.
package regbank_pkg;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    function automatic logic [NREG-1:0] onehot16(input logic [AW-1:0] a);
        onehot16 = NREG'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of register-write requests; push is ignored when full,
// pop is ignored when empty.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  wr_req_t                 din_i,
    input  logic                    pop_i,
    output wr_req_t                 dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wr_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-back stage: arbitrates load/ALU write requests into a FIFO, retires one
// write per cycle as one-hot select + Din, and publishes a pending-write mask.
module reg_writeback_ctrl
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [AW-1:0]           alu_addr,
    input  logic [DW-1:0]           alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [AW-1:0]           ld_addr,
    input  logic [DW-1:0]           ld_data,
    output logic [NREG-1:0]         select,
    output logic [DW-1:0]           Din,
    output logic [NREG-1:0]         pend_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    wr_req_t         push_req, head;
    logic            fifo_push, fifo_pop, full, empty;
    logic [NREG-1:0] select_q, select_d;
    logic [DW-1:0]   din_q, din_d;
    logic [NREG-1:0] push_hit, pop_hit;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];

    // Load has fixed priority; the ALU is only offered a slot when no load is waiting.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign fifo_push = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    assign push_req  = ld_valid ? wr_req_t'{addr: ld_addr,  data: ld_data}
                                : wr_req_t'{addr: alu_addr, data: alu_data};
    assign fifo_pop  = !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_req),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        select_d = '0;
        din_d    = din_q;
        if (fifo_pop) begin
            select_d = onehot16(head.addr);
            din_d    = head.data;
        end
    end

    assign push_hit = fifo_push ? onehot16(push_req.addr) : '0;
    assign pop_hit  = fifo_pop  ? onehot16(head.addr)     : '0;

    always_comb begin
        pend_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            unique case ({push_hit[r], pop_hit[r]})
                2'b10:   cnt_d[r] = cnt_q[r] + CW'(1);
                2'b01:   cnt_d[r] = cnt_q[r] - CW'(1);
                default: cnt_d[r] = cnt_q[r];
            endcase
            pend_mask[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_q <= '0;
            din_q    <= '0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            select_q <= select_d;
            din_q    <= din_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign select = select_q;
    assign Din    = din_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus random
// traffic, compared against a queue-based model of the write-back stage.
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [3:0]  alu_addr, ld_addr;
    logic [31:0] alu_data, ld_data;
    logic [15:0] select, pend_mask;
    logic [31:0] Din;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        model_q[$];
    logic [15:0] exp_sel;
    logic [31:0] exp_din;
    int          n_checks = 0;
    int          n_fail   = 0;

    reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .select     (select),
        .Din        (Din),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        foreach (model_q[i]) m[model_q[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_sel = '0;
        exp_din = '0;
    endtask

    // One clock: drive requests, check readies, advance the model, check outputs.
    task automatic step(input bit lv, input logic [3:0] la, input logic [31:0] ldat,
                        input bit av, input logic [3:0] aa, input logic [31:0] adat,
                        output bit l_acc, output bit a_acc,
                        output bit lr_seen, output bit ar_seen);
        bit   full_m;
        ent_t e;
        @(negedge clk);
        ld_valid  = lv;  ld_addr  = la; ld_data  = ldat;
        alu_valid = av;  alu_addr = aa; alu_data = adat;
        #1;
        full_m  = (model_q.size() == DEPTH);
        lr_seen = ld_ready;
        ar_seen = alu_ready;
        n_checks += 2;
        if (ld_ready !== !full_m) begin
            n_fail++;
            $display("FAIL ld_ready: got %b expected %b", ld_ready, !full_m);
        end
        if (alu_ready !== (!full_m && !lv)) begin
            n_fail++;
            $display("FAIL alu_ready: got %b expected %b", alu_ready, !full_m && !lv);
        end
        @(posedge clk);
        l_acc = lv && !full_m;
        a_acc = av && !full_m && !lv;
        if (model_q.size() > 0) begin
            e       = model_q.pop_front();
            exp_sel = 16'h1 << e.a;
            exp_din = e.d;
        end else begin
            exp_sel = '0;
        end
        if (l_acc) model_q.push_back('{a: la, d: ldat});
        else if (a_acc) model_q.push_back('{a: aa, d: adat});
        #1;
        n_checks += 4;
        if (select !== exp_sel) begin
            n_fail++;
            $display("FAIL select: got %h expected %h", select, exp_sel);
        end
        if (Din !== exp_din) begin
            n_fail++;
            $display("FAIL Din: got %h expected %h", Din, exp_din);
        end
        if (pend_mask !== model_mask()) begin
            n_fail++;
            $display("FAIL pend_mask: got %h expected %h", pend_mask, model_mask());
        end
        if (fifo_count !== 3'(model_q.size())) begin
            n_fail++;
            $display("FAIL fifo_count: got %0d expected %0d", fifo_count, model_q.size());
        end
    endtask

    task automatic idle(input int n);
        bit la, aa, lr, ar;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, la, aa, lr, ar);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (select !== 16'h0)    begin n_fail++; $display("FAIL reset_select: got %h expected 0000", select); end
        if (Din !== 32'h0)       begin n_fail++; $display("FAIL reset_din: got %h expected 0", Din); end
        if (pend_mask !== 16'h0) begin n_fail++; $display("FAIL reset_pend: got %h expected 0000", pend_mask); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if (ld_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        if (alu_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
        #2 rst = 1'b0;
    endtask

    task automatic test_single();
        bit la, aa, lr, ar;
        step(0, 0, 0, 1, 4'd3, 32'hD, la, aa, lr, ar);
        n_checks += 2;
        if (pend_mask !== 16'h0008) begin n_fail++; $display("FAIL single_pend_c1: got %h expected 0008", pend_mask); end
        if (select !== 16'h0000)    begin n_fail++; $display("FAIL single_sel_c1: got %h expected 0000", select); end
        idle(1);
        n_checks += 3;
        if (select !== 16'h0008)    begin n_fail++; $display("FAIL single_sel_c2: got %h expected 0008", select); end
        if (Din !== 32'hD)          begin n_fail++; $display("FAIL single_din_c2: got %h expected 0000000d", Din); end
        if (pend_mask !== 16'h0000) begin n_fail++; $display("FAIL single_pend_c2: got %h expected 0000", pend_mask); end
        idle(1);
        n_checks += 1;
        if (select !== 16'h0000)    begin n_fail++; $display("FAIL single_sel_c3: got %h expected 0000", select); end
    endtask

    task automatic test_priority();
        bit la, aa, lr, ar;
        step(1, 4'd5, 32'h15, 1, 4'd6, 32'h16, la, aa, lr, ar);
        n_checks += 1;
        if (ar !== 1'b0) begin n_fail++; $display("FAIL prio_alu_ready: got %b expected 0", ar); end
        step(0, 0, 0, 1, 4'd6, 32'h16, la, aa, lr, ar);
        n_checks += 1;
        if (select !== 16'h0020) begin n_fail++; $display("FAIL prio_first: got %h expected 0020", select); end
        idle(1);
        n_checks += 2;
        if (select !== 16'h0040) begin n_fail++; $display("FAIL prio_second: got %h expected 0040", select); end
        if (Din !== 32'h16)      begin n_fail++; $display("FAIL prio_second_din: got %h expected 00000016", Din); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        bit   la, aa, lr, ar;
        int   max_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 4'(i), 32'(10 + i), la, aa, lr, ar);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (i > 0) begin
                n_checks += 2;
                if (select !== (16'h1 << (i - 1))) begin
                    n_fail++; $display("FAIL b2b_sel[%0d]: got %h expected %h", i - 1, select, 16'h1 << (i - 1));
                end
                if (Din !== 32'(10 + i - 1)) begin
                    n_fail++; $display("FAIL b2b_din[%0d]: got %0d expected %0d", i - 1, Din, 10 + i - 1);
                end
            end
        end
        idle(1);
        n_checks += 3;
        if (select !== 16'h8000) begin n_fail++; $display("FAIL b2b_sel[15]: got %h expected 8000", select); end
        if (Din !== 32'd25)      begin n_fail++; $display("FAIL b2b_din[15]: got %0d expected 25", Din); end
        if (max_cnt > DEPTH)     begin n_fail++; $display("FAIL b2b_max_count: got %0d expected <= %0d", max_cnt, DEPTH); end
        idle(1);
    endtask

    task automatic test_same_reg();
        bit la, aa, lr, ar;
        step(0, 0, 0, 1, 4'd9, 32'h91, la, aa, lr, ar);
        n_checks += 1;
        if (pend_mask[9] !== 1'b1) begin n_fail++; $display("FAIL same_pend_1: got %b expected 1", pend_mask[9]); end
        step(0, 0, 0, 1, 4'd9, 32'h92, la, aa, lr, ar);
        n_checks += 3;
        if (pend_mask[9] !== 1'b1) begin n_fail++; $display("FAIL same_pend_2: got %b expected 1", pend_mask[9]); end
        if (select !== 16'h0200)   begin n_fail++; $display("FAIL same_sel_1: got %h expected 0200", select); end
        if (Din !== 32'h91)        begin n_fail++; $display("FAIL same_din_1: got %h expected 00000091", Din); end
        idle(1);
        n_checks += 3;
        if (select !== 16'h0200)   begin n_fail++; $display("FAIL same_sel_2: got %h expected 0200", select); end
        if (Din !== 32'h92)        begin n_fail++; $display("FAIL same_din_2: got %h expected 00000092", Din); end
        if (pend_mask[9] !== 1'b0) begin n_fail++; $display("FAIL same_pend_3: got %b expected 0", pend_mask[9]); end
        idle(1);
    endtask

    // Both producers pushing every cycle: the FIFO drains as fast as it fills.
    task automatic test_saturate();
        bit la, aa, lr, ar;
        for (int i = 0; i < 8; i++) begin
            step(1, 4'($urandom_range(0, 15)), $urandom, 1, 4'($urandom_range(0, 15)), $urandom,
                 la, aa, lr, ar);
            n_checks += 2;
            if (ar !== 1'b0) begin n_fail++; $display("FAIL sat_alu_ready: got %b expected 0", ar); end
            if (int'(fifo_count) > DEPTH) begin
                n_fail++; $display("FAIL sat_count: got %0d expected <= %0d", fifo_count, DEPTH);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        bit la, aa, lr, ar;
        step(0, 0, 0, 1, 4'd7, 32'h77, la, aa, lr, ar);
        step(0, 0, 0, 1, 4'd8, 32'h88, la, aa, lr, ar);
        #2;
        rst = 1'b1;
        ld_valid = 0; alu_valid = 0;
        #1;
        model_reset();
        n_checks += 4;
        if (select !== 16'h0)    begin n_fail++; $display("FAIL async_select: got %h expected 0000", select); end
        if (Din !== 32'h0)       begin n_fail++; $display("FAIL async_din: got %h expected 0", Din); end
        if (pend_mask !== 16'h0) begin n_fail++; $display("FAIL async_pend: got %h expected 0000", pend_mask); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", fifo_count); end
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle(1);
            n_checks += 1;
            if (select !== 16'h0) begin n_fail++; $display("FAIL stale_write: got %h expected 0000", select); end
        end
    endtask

    // Random traffic; each producer holds its request stable until accepted.
    task automatic test_random();
        bit          l_pend = 0, a_pend = 0, la, aa, lr, ar;
        logic [3:0]  l_a = 0, a_a = 0;
        logic [31:0] l_d = 0, a_d = 0;
        for (int i = 0; i < 300; i++) begin
            if (!l_pend && ($urandom_range(0, 3) == 0)) begin
                l_pend = 1; l_a = 4'($urandom_range(0, 15)); l_d = $urandom;
            end
            if (!a_pend && ($urandom_range(0, 1) == 0)) begin
                a_pend = 1; a_a = 4'($urandom_range(0, 15)); a_d = $urandom;
            end
            step(l_pend, l_a, l_d, a_pend, a_a, a_d, la, aa, lr, ar);
            if (la) l_pend = 0;
            if (aa) a_pend = 0;
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_same_reg();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
